// File: rtl/mem_ref_pkg.sv
// Shared types and constants for the memory-reference sequencer.
package mem_ref_pkg;

    localparam int         OPCODE_W = 5;
    localparam logic [4:0] OP_LD    = 5'b00000;
    localparam logic [4:0] OP_LDI   = 5'b00001;
    localparam logic [4:0] OP_ST    = 5'b00010;
    localparam logic [4:0] ALU_ADD  = 5'b00011;

    // Sequencer states; the encoding is visible on state_dbg.
    typedef enum logic [3:0] {
        IDLE = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T6   = 4'd7,
        T7   = 4'd8
    } state_t;

    // Instruction class latched at T3 and held through T7.
    typedef enum logic [1:0] {
        LD  = 2'd0,
        LDI = 2'd1,
        ST  = 2'd2
    } instr_cls_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter: counts cycles spent waiting for mem_ready and
// flags when WAIT_MAX waiting cycles have elapsed.
module mem_wait_timer #(
    parameter int WAIT_MAX = 4
) (
    input  logic Clock,
    input  logic clr,
    input  logic inc,
    input  logic clear,
    output logic first,
    output logic timeout
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    logic [CW-1:0] cnt;

    // Count held cycles; clear whenever the wait state is left or resolved.
    always_ff @(posedge Clock or negedge clr) begin
        if (!clr)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 1'b1;
    end

    assign first   = (cnt == '0);
    assign timeout = (cnt == CW'(WAIT_MAX));

endmodule

// File: rtl/mem_ref_sequencer.sv
// Control sequencer for ld / ldi / st: drives the datapath strobes from a
// T0..T7 state machine with a memory-ready handshake, timeout and run/halt.
module mem_ref_sequencer #(
    parameter int                    OPCODE_W = mem_ref_pkg::OPCODE_W,
    parameter logic [OPCODE_W-1:0]   OP_LD    = mem_ref_pkg::OP_LD,
    parameter logic [OPCODE_W-1:0]   OP_LDI   = mem_ref_pkg::OP_LDI,
    parameter logic [OPCODE_W-1:0]   OP_ST    = mem_ref_pkg::OP_ST,
    parameter logic [OPCODE_W-1:0]   ALU_ADD  = mem_ref_pkg::ALU_ADD,
    parameter int                    WAIT_MAX = 4
) (
    input  logic                Clock,
    input  logic                clr,
    input  logic                run,
    input  logic [OPCODE_W-1:0] ir_opcode,
    input  logic                mem_ready,
    output logic                PC_out,
    output logic                IncPC,
    output logic                PC_enable,
    output logic                MAR_enable,
    output logic                Read,
    output logic                MDR_enable,
    output logic                MDR_out,
    output logic                IR_enable,
    output logic                Grb,
    output logic                BA_out,
    output logic                Y_enable,
    output logic                C_out,
    output logic                Z_enable,
    output logic                ZLow_out,
    output logic                Gra,
    output logic                R_in,
    output logic                R_out,
    output logic                RAM_write_enable,
    output logic [OPCODE_W-1:0] opcode,
    output logic                busy,
    output logic                instr_done,
    output logic                illegal,
    output logic                mem_err,
    output logic [3:0]          state_dbg
);

    import mem_ref_pkg::*;

    state_t     state_q, state_n;
    instr_cls_t cls_q;

    logic wait_st, hold, fault, legal;
    logic tmr_first, tmr_timeout;

    // A state waits on memory only for the class that actually accesses it there.
    assign wait_st = (state_q == T1) ||
                     (state_q == T6 && cls_q == LD) ||
                     (state_q == T7 && cls_q == ST);
    assign hold    = wait_st && !mem_ready && !tmr_timeout;
    // A ready arriving on the timeout cycle still completes the handshake.
    assign fault   = wait_st &&  tmr_timeout && !mem_ready;
    assign legal   = (ir_opcode == OP_LD) || (ir_opcode == OP_LDI) ||
                     (ir_opcode == OP_ST);

    mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
        .Clock   (Clock),
        .clr     (clr),
        .inc     (hold),
        .clear   (!hold),
        .first   (tmr_first),
        .timeout (tmr_timeout)
    );

    // State register.
    always_ff @(posedge Clock or negedge clr) begin
        if (!clr)
            state_q <= IDLE;
        else
            state_q <= state_n;
    end

    // Latch the instruction class at decode so later IR changes are ignored.
    always_ff @(posedge Clock or negedge clr) begin
        if (!clr)
            cls_q <= LD;
        else if (state_q == T3 && legal) begin
            if (ir_opcode == OP_LDI)
                cls_q <= LDI;
            else if (ir_opcode == OP_ST)
                cls_q <= ST;
            else
                cls_q <= LD;
        end
    end

    // Next-state and strobe decode; a timeout drops every strobe.
    always_comb begin
        state_n          = state_q;
        PC_out           = 1'b0;
        IncPC            = 1'b0;
        PC_enable        = 1'b0;
        MAR_enable       = 1'b0;
        Read             = 1'b0;
        MDR_enable       = 1'b0;
        MDR_out          = 1'b0;
        IR_enable        = 1'b0;
        Grb              = 1'b0;
        BA_out           = 1'b0;
        Y_enable         = 1'b0;
        C_out            = 1'b0;
        Z_enable         = 1'b0;
        ZLow_out         = 1'b0;
        Gra              = 1'b0;
        R_in             = 1'b0;
        R_out            = 1'b0;
        RAM_write_enable = 1'b0;
        opcode           = '0;
        instr_done       = 1'b0;
        illegal          = 1'b0;
        mem_err          = 1'b0;
        if (fault) begin
            mem_err = 1'b1;
            state_n = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (run) state_n = T0;
                end
                T0: begin
                    PC_out     = 1'b1;
                    MAR_enable = 1'b1;
                    IncPC      = 1'b1;
                    Z_enable   = 1'b1;
                    state_n    = T1;
                end
                T1: begin
                    ZLow_out   = 1'b1;
                    PC_enable  = tmr_first;
                    Read       = 1'b1;
                    MDR_enable = 1'b1;
                    if (mem_ready) state_n = T2;
                end
                T2: begin
                    MDR_out   = 1'b1;
                    IR_enable = 1'b1;
                    state_n   = T3;
                end
                T3: begin
                    Grb      = 1'b1;
                    BA_out   = 1'b1;
                    Y_enable = 1'b1;
                    if (legal)
                        state_n = T4;
                    else begin
                        illegal = 1'b1;
                        state_n = run ? T0 : IDLE;
                    end
                end
                T4: begin
                    C_out    = 1'b1;
                    Z_enable = 1'b1;
                    opcode   = ALU_ADD;
                    state_n  = T5;
                end
                T5: begin
                    ZLow_out = 1'b1;
                    if (cls_q == LDI) begin
                        Gra        = 1'b1;
                        R_in       = 1'b1;
                        instr_done = 1'b1;
                        state_n    = run ? T0 : IDLE;
                    end else begin
                        MAR_enable = 1'b1;
                        state_n    = T6;
                    end
                end
                T6: begin
                    MDR_enable = 1'b1;
                    if (cls_q == LD) begin
                        Read = 1'b1;
                        if (mem_ready) state_n = T7;
                    end else begin
                        // MDR captures the register from the bus for the store.
                        Gra     = 1'b1;
                        R_out   = 1'b1;
                        state_n = T7;
                    end
                end
                T7: begin
                    if (cls_q == ST) begin
                        RAM_write_enable = 1'b1;
                        if (mem_ready) begin
                            instr_done = 1'b1;
                            state_n    = run ? T0 : IDLE;
                        end
                    end else begin
                        MDR_out    = 1'b1;
                        Gra        = 1'b1;
                        R_in       = 1'b1;
                        instr_done = 1'b1;
                        state_n    = run ? T0 : IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_ref_sequencer.sv
// Scoreboard bench: the stimulus process pushes the hand-computed output
// vector for every cycle it drives; a monitor pops and compares each cycle.
module tb_mem_ref_sequencer;

    logic       Clock = 1'b0;
    logic       clr = 1'b1;
    logic       run = 1'b0;
    logic [4:0] ir_opcode = 5'd0;
    logic       mem_ready = 1'b0;

    logic PC_out, IncPC, PC_enable, MAR_enable, Read, MDR_enable, MDR_out, IR_enable;
    logic Grb, BA_out, Y_enable, C_out, Z_enable, ZLow_out, Gra, R_in, R_out, RAM_write_enable;
    logic [4:0] opcode;
    logic busy, instr_done, illegal, mem_err;
    logic [3:0] state_dbg;

    mem_ref_sequencer #(.WAIT_MAX(4)) dut (
        .Clock(Clock), .clr(clr), .run(run), .ir_opcode(ir_opcode), .mem_ready(mem_ready),
        .PC_out(PC_out), .IncPC(IncPC), .PC_enable(PC_enable), .MAR_enable(MAR_enable),
        .Read(Read), .MDR_enable(MDR_enable), .MDR_out(MDR_out), .IR_enable(IR_enable),
        .Grb(Grb), .BA_out(BA_out), .Y_enable(Y_enable), .C_out(C_out), .Z_enable(Z_enable),
        .ZLow_out(ZLow_out), .Gra(Gra), .R_in(R_in), .R_out(R_out),
        .RAM_write_enable(RAM_write_enable), .opcode(opcode), .busy(busy),
        .instr_done(instr_done), .illegal(illegal), .mem_err(mem_err), .state_dbg(state_dbg)
    );

    always #5 Clock = ~Clock;

    // Output vector: [3:0] state, [8:4] opcode, bits 9.. strobes and flags.
    localparam logic [31:0] PCO  = 32'h1 << 9,  INC  = 32'h1 << 10, PCE  = 32'h1 << 11;
    localparam logic [31:0] MARE = 32'h1 << 12, RD   = 32'h1 << 13, MDRE = 32'h1 << 14;
    localparam logic [31:0] MDRO = 32'h1 << 15, IRE  = 32'h1 << 16, GRB  = 32'h1 << 17;
    localparam logic [31:0] BAO  = 32'h1 << 18, YE   = 32'h1 << 19, CO   = 32'h1 << 20;
    localparam logic [31:0] ZE   = 32'h1 << 21, ZLO  = 32'h1 << 22, GRA  = 32'h1 << 23;
    localparam logic [31:0] RIN  = 32'h1 << 24, ROUT = 32'h1 << 25, RAMW = 32'h1 << 26;
    localparam logic [31:0] BUSY = 32'h1 << 27, DONE = 32'h1 << 28, ILL  = 32'h1 << 29;
    localparam logic [31:0] MERR = 32'h1 << 30, ADD  = 32'h3 << 4;

    localparam logic [31:0] E_IDLE = 32'h0;
    localparam logic [31:0] E_T0   = 32'd1 | BUSY | PCO | MARE | INC | ZE;
    localparam logic [31:0] E_T1F  = 32'd2 | BUSY | ZLO | PCE | RD | MDRE;
    localparam logic [31:0] E_T1   = 32'd2 | BUSY | ZLO | RD | MDRE;
    localparam logic [31:0] E_T2   = 32'd3 | BUSY | MDRO | IRE;
    localparam logic [31:0] E_T3   = 32'd4 | BUSY | GRB | BAO | YE;
    localparam logic [31:0] E_T4   = 32'd5 | BUSY | CO | ZE | ADD;
    localparam logic [31:0] E_T5M  = 32'd6 | BUSY | ZLO | MARE;
    localparam logic [31:0] E_T5I  = 32'd6 | BUSY | ZLO | GRA | RIN | DONE;
    localparam logic [31:0] E_T6L  = 32'd7 | BUSY | RD | MDRE;
    localparam logic [31:0] E_T6S  = 32'd7 | BUSY | GRA | ROUT | MDRE;
    localparam logic [31:0] E_T7L  = 32'd8 | BUSY | MDRO | GRA | RIN | DONE;
    localparam logic [31:0] E_T7S  = 32'd8 | BUSY | RAMW;
    localparam logic [31:0] E_FLT1 = 32'd2 | BUSY | MERR;

    wire [31:0] obs = {1'b0, mem_err, illegal, instr_done, busy, RAM_write_enable, R_out,
                       R_in, Gra, ZLow_out, Z_enable, C_out, Y_enable, BA_out, Grb,
                       IR_enable, MDR_out, MDR_enable, Read, MAR_enable, PC_enable, IncPC,
                       PC_out, opcode, state_dbg};

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    sb_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;
    bit  stim_done = 1'b0;

    // Monitor: one expected vector per cycle, sampled mid-cycle.
    always @(negedge Clock) begin
        if (sb.size() > 0) begin
            sb_t e;
            e = sb.pop_front();
            n_vec++;
            if (obs !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
            end
        end
    end

    // Drive one cycle's inputs just after the edge and queue its expected outputs.
    task automatic step(input string name, input logic c, input logic r,
                        input logic rdy, input logic [4:0] op, input logic [31:0] exp);
        sb_t e;
        @(posedge Clock);
        #1;
        clr       = c;
        run       = r;
        mem_ready = rdy;
        ir_opcode = op;
        e.name    = name;
        e.exp     = exp;
        sb.push_back(e);
    endtask

    initial begin
        #2 clr = 1'b0;
        // reset state
        step("rst0", 0, 0, 0, 5'd0, E_IDLE);
        step("rst1", 0, 1, 1, 5'd0, E_IDLE);
        step("idle", 1, 0, 1, 5'd0, E_IDLE);

        // ld with memory always ready; run drops mid-instruction
        step("ld_idle", 1, 1, 1, 5'd0, E_IDLE);
        step("ld_t0",   1, 1, 1, 5'd0, E_T0);
        step("ld_t1",   1, 1, 1, 5'd0, E_T1F);
        step("ld_t2",   1, 1, 1, 5'd0, E_T2);
        step("ld_t3",   1, 1, 1, 5'b00000, E_T3);
        step("ld_t4",   1, 0, 1, 5'd7, E_T4);
        step("ld_t5",   1, 0, 1, 5'd7, E_T5M);
        step("ld_t6",   1, 0, 1, 5'd7, E_T6L);
        step("ld_t7",   1, 0, 1, 5'd7, E_T7L);
        step("ld_end",  1, 0, 1, 5'd0, E_IDLE);

        // ldi completes in T5
        step("ldi_idle", 1, 1, 1, 5'd0, E_IDLE);
        step("ldi_t0",   1, 1, 1, 5'd0, E_T0);
        step("ldi_t1",   1, 1, 1, 5'd0, E_T1F);
        step("ldi_t2",   1, 1, 1, 5'd0, E_T2);
        step("ldi_t3",   1, 1, 1, 5'b00001, E_T3);
        step("ldi_t4",   1, 1, 1, 5'b00000, E_T4);
        step("ldi_t5",   1, 0, 1, 5'b00000, E_T5I);
        step("ldi_end",  1, 0, 1, 5'd0, E_IDLE);

        // st with mem_ready low for two T7 cycles, run kept high
        step("st_idle", 1, 1, 1, 5'd0, E_IDLE);
        step("st_t0",   1, 1, 1, 5'd0, E_T0);
        step("st_t1",   1, 1, 1, 5'd0, E_T1F);
        step("st_t2",   1, 1, 1, 5'd0, E_T2);
        step("st_t3",   1, 1, 1, 5'b00010, E_T3);
        step("st_t4",   1, 1, 0, 5'd0, E_T4);
        step("st_t5",   1, 1, 0, 5'd0, E_T5M);
        step("st_t6",   1, 1, 0, 5'd0, E_T6S);
        step("st_t7a",  1, 1, 0, 5'd0, E_T7S);
        step("st_t7b",  1, 1, 0, 5'd0, E_T7S);
        step("st_t7c",  1, 1, 1, 5'd0, E_T7S | DONE);

        // illegal opcode, back to T0 with run high
        step("ill_t0",  1, 1, 1, 5'd0, E_T0);
        step("ill_t1",  1, 1, 1, 5'd0, E_T1F);
        step("ill_t2",  1, 1, 1, 5'd0, E_T2);
        step("ill_t3",  1, 1, 1, 5'b00011, E_T3 | ILL);

        // T1 timeout: four waiting cycles then mem_err, IDLE despite run
        step("to_t0",   1, 1, 0, 5'd0, E_T0);
        step("to_w0",   1, 1, 0, 5'd0, E_T1F);
        step("to_w1",   1, 1, 0, 5'd0, E_T1);
        step("to_w2",   1, 1, 0, 5'd0, E_T1);
        step("to_w3",   1, 1, 0, 5'd0, E_T1);
        step("to_err",  1, 1, 0, 5'd0, E_FLT1);
        step("to_idle", 1, 1, 0, 5'd0, E_IDLE);

        // ready on the timeout cycle wins; then ld reset mid-T6
        step("hw_t0",   1, 1, 0, 5'd0, E_T0);
        step("hw_w0",   1, 1, 0, 5'd0, E_T1F);
        step("hw_w1",   1, 1, 0, 5'd0, E_T1);
        step("hw_w2",   1, 1, 0, 5'd0, E_T1);
        step("hw_w3",   1, 1, 0, 5'd0, E_T1);
        step("hw_win",  1, 1, 1, 5'd0, E_T1);
        step("hw_t2",   1, 1, 1, 5'd0, E_T2);
        step("hw_t3",   1, 1, 1, 5'b00000, E_T3);
        step("hw_t4",   1, 1, 0, 5'd0, E_T4);
        step("hw_t5",   1, 1, 0, 5'd0, E_T5M);
        step("hw_t6a",  1, 1, 0, 5'd0, E_T6L);
        step("hw_t6b",  1, 1, 0, 5'd0, E_T6L);
        step("clr_mid", 0, 1, 0, 5'd0, E_IDLE);
        step("clr_hold",0, 1, 1, 5'd0, E_IDLE);
        step("clr_rel", 1, 1, 1, 5'd0, E_IDLE);
        step("re_t0",   1, 1, 1, 5'd0, E_T0);
        step("re_t1",   1, 0, 1, 5'd0, E_T1F);
        step("re_t2",   1, 0, 1, 5'd0, E_T2);
        step("re_t3",   1, 0, 1, 5'b00000, E_T3);
        step("re_t4",   1, 0, 1, 5'd0, E_T4);
        step("re_t5",   1, 0, 1, 5'd0, E_T5M);
        step("re_t6",   1, 0, 1, 5'd0, E_T6L);
        step("re_t7",   1, 0, 1, 5'd0, E_T7L);
        step("re_end",  1, 0, 1, 5'd0, E_IDLE);

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge Clock);
        @(posedge Clock);
        if (sb.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d vectors left, expected 0", sb.size());
        end
        stim_done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        if (!stim_done) begin
            $display("FAIL watchdog: simulation time limit reached, expected completion");
            $fatal(1, "watchdog");
        end
    end

endmodule
